// File: rtl/reset_sequencer_pkg.sv
// Shared types and default constants for the reset sequencer.
// The FSM state encoding lives here so the top and any future sub-blocks agree on it.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    STEP = 2'd1,
    RUN  = 2'd2
  } seq_state_t;

  localparam int DEF_N_DOMAINS      = 4;
  localparam int DEF_HOLD_CYCLES    = 16;
  localparam int DEF_GAP_CYCLES     = 4;
  localparam int DEF_TIMEOUT_CYCLES = 64;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_sequencer_ack_sync.sv
// 1-bit, 3-stage synchronizer for a domain's asynchronous "out of reset" ack.
// All stages clear on the synchronous reset so a stale ack is never seen after a restart.
module ack_sync_3 (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [2:0] stage;

  always_ff @(posedge clock) begin
    if (reset) begin
      stage <= '0;
    end else begin
      stage <= {stage[1:0], d};
    end
  end

  assign q = stage[2];

endmodule

// File: rtl/reset_sequencer.sv
// Releases N_DOMAINS downstream resets one at a time after a fixed hold period,
// pacing each release on a synchronized ack with a minimum gap and a timeout.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int N_DOMAINS      = DEF_N_DOMAINS,
  parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 io_req,
  input  logic [N_DOMAINS-1:0] io_ack,
  output logic [N_DOMAINS-1:0] io_domain_rst,
  output logic                 io_busy,
  output logic                 io_done,
  output logic                 io_error
);

  localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, TIMEOUT_CYCLES)) + 1;
  localparam int IDX_W = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(N_DOMAINS - 1);

  seq_state_t             state;
  logic [CNT_W-1:0]       cnt;
  logic [IDX_W-1:0]       idx;
  logic [N_DOMAINS-1:0]   ack_s;

  logic                   ack_ok;
  logic                   timed_out;

  // Reset pattern while domain k is being stepped: only domains above k stay held.
  function automatic logic [N_DOMAINS-1:0] mask_above(input int k);
    logic [N_DOMAINS-1:0] m;
    for (int i = 0; i < N_DOMAINS; i++) begin
      m[i] = (i > k);
    end
    return m;
  endfunction

  for (genvar g = 0; g < N_DOMAINS; g++) begin : g_sync
    ack_sync_3 u_ack_sync (
      .clock (clock),
      .reset (reset),
      .d     (io_ack[g]),
      .q     (ack_s[g])
    );
  end

  // cnt counts completed cycles in the current state, so "elapsed" includes the current edge.
  assign ack_ok    = ack_s[idx] && (cnt >= GAP_LAST);
  assign timed_out = (cnt == TIMEOUT_LAST);

  // NOTE: the reset and restart branches load every flop, and all state updates use
  // non-blocking assignments so the outputs change together on one edge.
  always_ff @(posedge clock) begin
    if (reset || io_req) begin
      state         <= HOLD;
      cnt           <= '0;
      idx           <= '0;
      io_domain_rst <= '1;
      io_busy       <= 1'b1;
      io_done       <= 1'b0;
      io_error      <= 1'b0;
    end else begin
      unique case (state)
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            state         <= STEP;
            cnt           <= '0;
            idx           <= '0;
            io_domain_rst <= mask_above(0);
            io_busy       <= |mask_above(0);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        STEP: begin
          if (ack_ok || timed_out) begin
            cnt <= '0;
            if (!ack_ok) begin
              io_error <= 1'b1;
            end
            if (idx == IDX_LAST) begin
              state   <= RUN;
              io_done <= 1'b1;
            end else begin
              idx           <= idx + 1'b1;
              io_domain_rst <= mask_above(int'(idx) + 1);
              io_busy       <= |mask_above(int'(idx) + 1);
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        RUN: begin
          io_domain_rst <= '0;
          io_busy       <= 1'b0;
          io_done       <= 1'b1;
        end

        default: begin
          state         <= HOLD;
          cnt           <= '0;
          idx           <= '0;
          io_domain_rst <= '1;
          io_busy       <= 1'b1;
          io_done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Scenario bench for reset_sequencer: each test queues the expected output changes
// by cycle number and the runner compares the DUT against them every cycle.
module tb_reset_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       io_req = 1'b0;
  logic [3:0] io_ack = 4'h0;
  logic [3:0] io_domain_rst;
  logic       io_busy;
  logic       io_done;
  logic       io_error;

  int edges = 0;
  int base  = 0;
  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int         cyc;
    logic [3:0] rst;
    logic       busy;
    logic       done;
    logic       error;
  } exp_t;

  exp_t exp_q[$];

  reset_sequencer dut (
    .clock         (clock),
    .reset         (reset),
    .io_req        (io_req),
    .io_ack        (io_ack),
    .io_domain_rst (io_domain_rst),
    .io_busy       (io_busy),
    .io_done       (io_done),
    .io_error      (io_error)
  );

  always #5 clock = ~clock;
  always @(posedge clock) edges <= edges + 1;

  task automatic push_exp(input int c, input logic [3:0] r, input logic b,
                          input logic d, input logic e);
    exp_t t;
    t.cyc = c; t.rst = r; t.busy = b; t.done = d; t.error = e;
    exp_q.push_back(t);
  endtask

  // Hold reset for a few cycles, check the reset values, then release so that
  // the next rising edge is cycle 1.
  task automatic start_seq(input logic [3:0] ack);
    exp_q.delete();
    reset  = 1'b1;
    io_req = 1'b0;
    io_ack = ack;
    repeat (3) @(posedge clock);
    #1;
    vectors++;
    if ({io_domain_rst, io_busy, io_done, io_error} !== 7'b1111_100) begin
      miscompares++;
      $display("FAIL reset_values: got rst=%b busy=%b done=%b error=%b, want rst=1111 busy=1 done=0 error=0",
               io_domain_rst, io_busy, io_done, io_error);
    end
    base  = edges;
    reset = 1'b0;
  endtask

  task automatic run_seq(input string name, input int n, input int ack_cyc,
                         input logic [3:0] ack_val, input int req_cyc, input int rst_cyc);
    exp_t cur;
    cur = '{cyc: 0, rst: 4'b1111, busy: 1'b1, done: 1'b0, error: 1'b0};
    for (int c = 1; c <= n; c++) begin
      @(posedge clock);
      #1;
      while (exp_q.size() > 0 && exp_q[0].cyc == c) cur = exp_q.pop_front();
      vectors++;
      if ({io_domain_rst, io_busy, io_done, io_error} !== {cur.rst, cur.busy, cur.done, cur.error}) begin
        miscompares++;
        $display("FAIL %s cycle %0d: got rst=%b busy=%b done=%b error=%b, want rst=%b busy=%b done=%b error=%b",
                 name, c, io_domain_rst, io_busy, io_done, io_error,
                 cur.rst, cur.busy, cur.done, cur.error);
      end
      io_req = (c == req_cyc);
      reset  = (c == rst_cyc);
      if (c == ack_cyc) io_ack = ack_val;
    end
    io_req = 1'b0;
    reset  = 1'b0;
  endtask

  task automatic test_reset();
    start_seq(4'hF);
    run_seq("hold_period", 15, -1, 4'h0, -1, -1);
  endtask

  task automatic test_basic();
    start_seq(4'hF);
    push_exp(16, 4'b1110, 1, 0, 0);
    push_exp(20, 4'b1100, 1, 0, 0);
    push_exp(24, 4'b1000, 1, 0, 0);
    push_exp(28, 4'b0000, 0, 0, 0);
    push_exp(32, 4'b0000, 0, 1, 0);
    // acks drop at 34 while in RUN and must be ignored
    run_seq("basic", 40, 34, 4'h0, -1, -1);
  endtask

  task automatic test_timeout();
    start_seq(4'b1011);
    push_exp(16,  4'b1110, 1, 0, 0);
    push_exp(20,  4'b1100, 1, 0, 0);
    push_exp(24,  4'b1000, 1, 0, 0);
    push_exp(88,  4'b0000, 0, 0, 1);
    push_exp(92,  4'b0000, 0, 1, 1);
    // request from RUN clears the sticky error and re-sequences
    push_exp(96,  4'b1111, 1, 0, 0);
    push_exp(112, 4'b1110, 1, 0, 0);
    push_exp(116, 4'b1100, 1, 0, 0);
    push_exp(120, 4'b1000, 1, 0, 0);
    push_exp(184, 4'b0000, 0, 0, 1);
    push_exp(188, 4'b0000, 0, 1, 1);
    run_seq("timeout", 192, -1, 4'h0, 95, -1);
  endtask

  task automatic test_late_ack();
    start_seq(4'b1101);
    push_exp(16, 4'b1110, 1, 0, 0);
    push_exp(20, 4'b1100, 1, 0, 0);
    push_exp(34, 4'b1000, 1, 0, 0);
    push_exp(38, 4'b0000, 0, 0, 0);
    push_exp(42, 4'b0000, 0, 1, 0);
    run_seq("late_ack", 46, 30, 4'hF, -1, -1);
  endtask

  task automatic test_req_in_step();
    start_seq(4'hF);
    push_exp(16, 4'b1110, 1, 0, 0);
    push_exp(20, 4'b1100, 1, 0, 0);
    push_exp(23, 4'b1111, 1, 0, 0);
    push_exp(39, 4'b1110, 1, 0, 0);
    push_exp(43, 4'b1100, 1, 0, 0);
    push_exp(47, 4'b1000, 1, 0, 0);
    push_exp(51, 4'b0000, 0, 0, 0);
    push_exp(55, 4'b0000, 0, 1, 0);
    run_seq("req_in_step", 60, -1, 4'h0, 22, -1);
  endtask

  task automatic test_req_in_hold();
    start_seq(4'hF);
    push_exp(27, 4'b1110, 1, 0, 0);
    push_exp(31, 4'b1100, 1, 0, 0);
    push_exp(35, 4'b1000, 1, 0, 0);
    push_exp(39, 4'b0000, 0, 0, 0);
    push_exp(43, 4'b0000, 0, 1, 0);
    run_seq("req_in_hold", 48, -1, 4'h0, 10, -1);
  endtask

  task automatic test_reset_in_run();
    start_seq(4'hF);
    push_exp(16,  4'b1110, 1, 0, 0);
    push_exp(20,  4'b1100, 1, 0, 0);
    push_exp(24,  4'b1000, 1, 0, 0);
    push_exp(28,  4'b0000, 0, 0, 0);
    push_exp(32,  4'b0000, 0, 1, 0);
    push_exp(101, 4'b1111, 1, 0, 0);
    push_exp(117, 4'b1110, 1, 0, 0);
    push_exp(121, 4'b1100, 1, 0, 0);
    push_exp(125, 4'b1000, 1, 0, 0);
    push_exp(129, 4'b0000, 0, 0, 0);
    push_exp(133, 4'b0000, 0, 1, 0);
    run_seq("reset_in_run", 140, -1, 4'h0, -1, 100);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_late_ack();
    test_req_in_step();
    test_req_in_hold();
    test_reset_in_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
